// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator fetch path.
//   BRAM_DATA_W / BRAM_ADDR_W : activation BRAM word and byte-address widths
//   BYTE_OFFSET               : log2 of bytes per BRAM word
//   fetch_state_e             : fetch FSM encoding (IDLE / RUN / DRAIN)
//   fifo_entry_t              : stream FIFO payload, {last, data}
//   word_to_byte()            : word index -> byte address
package accel_pkg;

  localparam int BRAM_DATA_W = 32;
  localparam int BRAM_ADDR_W = 32;
  localparam int BYTE_OFFSET = 2;
  localparam int WORD_PTR_W  = BRAM_ADDR_W - BYTE_OFFSET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                   last;
    logic [BRAM_DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic logic [BRAM_ADDR_W-1:0] word_to_byte(
    input logic [WORD_PTR_W-1:0] word_idx
  );
    return {word_idx, {BYTE_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO carrying {last, data} stream entries.
//   clk, rst_ni   : clock, asynchronous active-low reset (empties FIFO, clears storage)
//   push_i        : write push_data_i (dropped only if full with no pop)
//   pop_i         : remove head (ignored when empty)
//   full_o/empty_o: occupancy flags
//   count_o       : current number of entries
//   head_o        : entry at the head, valid while !empty_o
module fetch_fifo
  import accel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  fifo_entry_t                  push_data_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output fifo_entry_t                  head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push_s = push_i & (~full_o | pop_i);
  assign do_pop_s  = pop_i & ~empty_o;

  // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifmap_fetch.sv
// Input-feature-map fetch engine: reads num_words consecutive words from the
// activation BRAM starting at base_addr and streams them out in order.
//   clk, rst            : clock, asynchronous active-low reset
//   start, base_addr,
//   num_words           : transfer request (sampled only when idle)
//   busy, done          : transfer status; done pulses once per transfer
//   bram_*              : BRAM port (read-only use, 1-cycle registered read)
//   m_valid/m_ready,
//   m_data/m_last       : output stream, m_last marks the final word
module ifmap_fetch
  import accel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BRAM_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]       num_words,
  output logic                   busy,
  output logic                   done,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic                   bram_en,
  output logic [3:0]             bram_wen,
  output logic [BRAM_DATA_W-1:0] bram_din,
  input  logic [BRAM_DATA_W-1:0] bram_dout,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [BRAM_DATA_W-1:0] m_data,
  output logic                   m_last
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W  = FCNT_W + 1;

  fetch_state_e          state_q, state_d;
  logic [WORD_PTR_W-1:0] word_ptr_q, word_ptr_d;
  logic [CNT_W-1:0]      issue_left_q, issue_left_d;
  logic                  en_q, en_d;
  logic                  inflight_q;
  logic                  last_inflight_q;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FCNT_W-1:0]     fifo_count_s;
  logic [FCNT_W-1:0]     fifo_cnt_d_s;
  logic [OUT_W-1:0]      outstanding_d_s;
  fifo_entry_t           push_entry_s;
  fifo_entry_t           head_s;
  logic                  base_unused_s;

  // Byte-offset bits of the base address are ignored.
  assign base_unused_s = ^base_addr[BYTE_OFFSET-1:0];

  // Data returns one cycle after the read; the credit rule means the FIFO always
  // has room, the full guard only prevents an overwrite should that ever break.
  assign fifo_push_s  = inflight_q & (~fifo_full_s | fifo_pop_s);
  assign fifo_pop_s   = ~fifo_empty_s & m_ready;
  assign push_entry_s = '{last: last_inflight_q, data: bram_dout};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (fifo_push_s),
    .push_data_i (push_entry_s),
    .pop_i       (fifo_pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s),
    .head_o      (head_s)
  );

  // Next-state, counters, and the read-issue decision for the following cycle.
  always_comb begin
    state_d      = state_q;
    word_ptr_d   = word_ptr_q;
    issue_left_d = issue_left_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // busy_q is still high in a done cycle, so a start there is ignored.
        if (start && !busy_q) begin
          if (num_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = RUN;
            word_ptr_d   = base_addr[BRAM_ADDR_W-1:BYTE_OFFSET];
            issue_left_d = num_words;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (en_q) begin
          word_ptr_d   = word_ptr_q + WORD_PTR_W'(1);
          issue_left_d = issue_left_q - CNT_W'(1);
          if (issue_left_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (fifo_pop_s && head_s.last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // bram_en is registered, so the credit test looks one cycle ahead: FIFO
    // occupancy next cycle plus the read issued this cycle (in flight next cycle).
    fifo_cnt_d_s    = fifo_count_s + FCNT_W'(fifo_push_s) - FCNT_W'(fifo_pop_s);
    outstanding_d_s = {1'b0, fifo_cnt_d_s} + OUT_W'(en_q);
    en_d            = (state_d == RUN) && (issue_left_d != '0) &&
                      (outstanding_d_s < OUT_W'(FIFO_DEPTH));

    busy_d = (state_d != IDLE) | done_d;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      word_ptr_q      <= '0;
      issue_left_q    <= '0;
      en_q            <= 1'b0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_ptr_q      <= word_ptr_d;
      issue_left_q    <= issue_left_d;
      en_q            <= en_d;
      inflight_q      <= en_q;
      last_inflight_q <= en_q & (issue_left_q == CNT_W'(1));
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bram_en   = en_q;
  assign bram_addr = word_to_byte(word_ptr_q);
  assign bram_wen  = 4'b0000;
  assign bram_din  = '0;
  assign m_valid   = ~fifo_empty_s;
  assign m_data    = head_s.data;
  assign m_last    = head_s.last;

endmodule

// File: tb/tb_ifmap_fetch.sv
module tb_ifmap_fetch;

  localparam int DEPTH = 4;
  localparam int MEMW  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] num_words = 16'd0;
  logic        busy, done, bram_en, m_valid, m_last;
  logic [31:0] bram_addr, bram_din, m_data;
  logic [3:0]  bram_wen;
  logic [31:0] bram_dout = 32'd0;
  logic        m_ready = 1'b0;

  ifmap_fetch #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_wen(bram_wen), .bram_din(bram_din), .bram_dout(bram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // BRAM model: 1-cycle registered read, word index = addr>>2 (wraps over the model size)
  logic [31:0] mem [MEMW];
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr[9:2]];

  int checks = 0;
  int errors = 0;

  // observations gathered by xfer()
  logic [31:0] got_data[$];
  bit          got_last[$];
  int n_done, done_cyc, first_hs, last_hs, first_valid, busy_cnt;
  int stall_viol, credit_viol, en_cnt, timed_out;
  logic [31:0] first_addr;

  // reference: the i-th word of a transfer starting at byte address b
  function automatic logic [31:0] exp_word(input logic [31:0] b, input int i);
    int idx;
    idx = (int'(b >> 2) + i) % MEMW;
    return mem[idx];
  endfunction

  // Runs one transfer and records what the stream/status outputs did.
  // mode 0: ready high, 1: ready pattern 1,0,0,1,1,0, 2: random ready.
  task automatic xfer(input logic [31:0] b, input int n, input int mode, input int start2_cyc);
    logic [5:0]  pat;
    logic        prev_stall, prev_last, rdy;
    logic [31:0] prev_data;
    int cyc, issued, popped;
    bit seen;
    pat = 6'b011001;
    got_data.delete(); got_last.delete();
    n_done = 0; done_cyc = -1; first_hs = -1; last_hs = -1; first_valid = -1;
    busy_cnt = 0; stall_viol = 0; credit_viol = 0; en_cnt = 0; first_addr = 32'hFFFF_FFFF;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = 32'd0;
    cyc = 0; issued = 0; popped = 0; seen = 0;
    start = 1'b1; base_addr = b; num_words = n[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000 && !(seen && cyc > done_cyc + 4)) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 6];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      if (start2_cyc >= 0 && cyc == start2_cyc) begin
        start = 1'b1; base_addr = 32'h200; num_words = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (bram_en) begin
        if (issued - popped >= DEPTH) credit_viol++;
        if (en_cnt == 0) first_addr = bram_addr;
        en_cnt++;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (!seen) done_cyc = cyc;
        seen = 1;
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        popped++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (bram_en) issued++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b0;
    timed_out = seen ? 0 : 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, bram_en, m_valid, m_last} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, bram_en, m_valid, m_last});
    end
    checks++;
    if (bram_addr !== 32'd0 || m_data !== 32'd0) begin
      errors++; $display("FAIL reset_data: addr %h data %h want 0 0", bram_addr, m_data);
    end
    checks++;
    if (bram_wen !== 4'd0 || bram_din !== 32'd0) begin
      errors++; $display("FAIL reset_ties: wen %h din %h want 0 0", bram_wen, bram_din);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    xfer(32'h0, 8, 0, -1);
    checks++;
    if (timed_out != 0 || got_data.size() != 8) begin
      errors++; $display("FAIL basic_count: words %0d timeout %0d want 8 0", got_data.size(), timed_out);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_word(32'h0, i) || got_last[i] !== (i == 7)) begin
        errors++; $display("FAIL basic_word%0d: got %h/%0d want %h/%0d", i, got_data[i], got_last[i], exp_word(32'h0, i), (i == 7));
      end
    end
    checks++;
    if (first_valid != 2) begin
      errors++; $display("FAIL basic_latency: first valid cycle %0d want 2", first_valid);
    end
    checks++;
    if (last_hs - first_hs != 7) begin
      errors++; $display("FAIL basic_throughput: span %0d want 7", last_hs - first_hs);
    end
    checks++;
    if (done_cyc != last_hs + 1 || n_done != 1) begin
      errors++; $display("FAIL basic_done: cycle %0d count %0d want %0d 1", done_cyc, n_done, last_hs + 1);
    end
    checks++;
    if (busy_cnt != done_cyc + 1) begin
      errors++; $display("FAIL basic_busy: busy cycles %0d want %0d", busy_cnt, done_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    xfer(32'h10, 20, 1, -1);
    checks++;
    if (timed_out != 0 || got_data.size() != 20) begin
      errors++; $display("FAIL bp_count: words %0d timeout %0d want 20 0", got_data.size(), timed_out);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_word(32'h10, i) || got_last[i] !== (i == 19)) begin
        errors++; $display("FAIL bp_word%0d: got %h/%0d want %h/%0d", i, got_data[i], got_last[i], exp_word(32'h10, i), (i == 19));
      end
    end
    checks++;
    if (stall_viol != 0 || credit_viol != 0) begin
      errors++; $display("FAIL bp_rules: stall %0d credit %0d want 0 0", stall_viol, credit_viol);
    end
    checks++;
    if (n_done != 1 || done_cyc != last_hs + 1) begin
      errors++; $display("FAIL bp_done: count %0d cycle %0d want 1 %0d", n_done, done_cyc, last_hs + 1);
    end
  endtask

  task automatic test_zero_len();
    xfer(32'h30, 0, 0, -1);
    checks++;
    if (timed_out != 0 || done_cyc != 0 || n_done != 1) begin
      errors++; $display("FAIL zero_done: cycle %0d count %0d want 0 1", done_cyc, n_done);
    end
    checks++;
    if (busy_cnt != 1) begin
      errors++; $display("FAIL zero_busy: busy cycles %0d want 1", busy_cnt);
    end
    checks++;
    if (en_cnt != 0 || first_valid != -1 || got_data.size() != 0) begin
      errors++; $display("FAIL zero_quiet: reads %0d valid@%0d words %0d want 0 -1 0", en_cnt, first_valid, got_data.size());
    end
  endtask

  task automatic test_start_busy();
    xfer(32'h20, 10, 2, 5);
    checks++;
    if (timed_out != 0 || got_data.size() != 10 || n_done != 1 || en_cnt != 10) begin
      errors++; $display("FAIL busy_start: words %0d done %0d reads %0d want 10 1 10", got_data.size(), n_done, en_cnt);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_word(32'h20, i) || got_last[i] !== (i == 9)) begin
        errors++; $display("FAIL busy_word%0d: got %h/%0d want %h/%0d", i, got_data[i], got_last[i], exp_word(32'h20, i), (i == 9));
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    bit dseen;
    hs = 0; dseen = 0;
    m_ready = 1'b1;
    start = 1'b1; base_addr = 32'h0; num_words = 16'd12;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60 && hs < 3; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      if (hs < 3) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (hs != 3) begin
      errors++; $display("FAIL rmid_reach: handshakes %0d want 3", hs);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, bram_en, m_valid, m_last} !== 5'b0 || bram_addr !== 32'd0 || m_data !== 32'd0) begin
      errors++; $display("FAIL rmid_outputs: ctrl %b addr %h data %h want 0", {busy, done, bram_en, m_valid, m_last}, bram_addr, m_data);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy || m_valid) dseen = 1;
    end
    checks++;
    if (dseen) begin
      errors++; $display("FAIL rmid_abandon: activity after reset seen 1 want 0");
    end
    @(posedge clk); #1;
    xfer(32'h40, 2, 0, -1);
    checks++;
    if (timed_out != 0 || got_data.size() != 2 || n_done != 1) begin
      errors++; $display("FAIL rmid_restart: words %0d done %0d want 2 1", got_data.size(), n_done);
    end else begin
      checks++;
      if (got_data[0] !== mem[16] || got_data[1] !== mem[17] || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
        errors++; $display("FAIL rmid_words: got %h/%0d %h/%0d want %h/0 %h/1", got_data[0], got_last[0], got_data[1], got_last[1], mem[16], mem[17]);
      end
    end
  endtask

  task automatic test_misaligned();
    xfer(32'h0B, 4, 0, -1);
    checks++;
    if (first_addr !== 32'h08) begin
      errors++; $display("FAIL mis_addr: first bram_addr %h want 00000008", first_addr);
    end
    checks++;
    if (got_data.size() != 4 || got_data[0] !== mem[2]) begin
      errors++; $display("FAIL mis_word: words %0d first %h want 4 %h", got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hX, mem[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    int n, s2;
    for (int t = 0; t < 8; t++) begin
      b  = 32'($urandom_range(0, 1023));
      n  = $urandom_range(1, 40);
      s2 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1;
      xfer(b, n, 2, s2);
      checks++;
      if (timed_out != 0 || got_data.size() != n || n_done != 1) begin
        errors++; $display("FAIL rnd%0d_count: words %0d done %0d want %0d 1", t, got_data.size(), n_done, n);
      end
      checks++;
      if (stall_viol != 0 || credit_viol != 0 || en_cnt != n) begin
        errors++; $display("FAIL rnd%0d_rules: stall %0d credit %0d reads %0d want 0 0 %0d", t, stall_viol, credit_viol, en_cnt, n);
      end
      for (int i = 0; i < got_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_word(b, i) || got_last[i] !== (i == n - 1)) begin
          errors++; $display("FAIL rnd%0d_word%0d: got %h/%0d want %h/%0d", t, i, got_data[i], got_last[i], exp_word(b, i), (i == n - 1));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = 32'h100 + 32'(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_misaligned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
